ifetch: RTL and testbench

Instruction-fetch stage: owns the program counter, issues single-outstanding word reads to instruction memory, and presents fetched instructions to decode with a valid/stall handshake. It sits directly upstream of decode/execute and consumes the branch/jump/trap unit's `taken`/`target` redirect. It produces `pipe_flush` to squash wrong-path work, and emits a misalignment bubble that execute turns into `ins_misalign`.

---
 rtl/ifetch.sv | 125 ++++++++++++
 tb/tb_ifetch.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch.sv
// Instruction-fetch stage: owns the PC, issues one outstanding word read at a
// time, and hands fetched words to decode through a valid/stall output register.
// Redirects squash the held entry, pulse pipe_flush, and either retarget the PC
// or, for a misaligned target, emit a NOP bubble flagged as misaligned.
module ifetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INS  = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        taken,
  input  logic [31:0] target,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_ins,
  output logic        if_misalign,
  output logic        pipe_flush
);

  typedef enum logic [1:0] {
    S_REQ     = 2'd0,
    S_WAIT    = 2'd1,
    S_DISCARD = 2'd2,
    S_HOLD    = 2'd3
  } state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic        valid_q;
  logic [31:0] out_pc_q;
  logic [31:0] out_ins_q;
  logic        out_mis_q;
  logic        flush_q;
  logic        hold_after_q;   // leave DISCARD for HOLD instead of REQ

  logic can_issue;
  logic accept;
  logic in_flight;

  // Request side is combinational from state, pc, output occupancy and stall.
  always_comb begin
    can_issue = !valid_q || !stall;
    imem_req  = (state_q == S_REQ) && can_issue && !rst;
    imem_addr = pc_q;
    accept    = imem_req && imem_ready;
    // A response arriving in the same cycle as the redirect is dropped right
    // now, so nothing remains outstanding for DISCARD to wait on.
    in_flight = accept ||
                (((state_q == S_WAIT) || (state_q == S_DISCARD)) && !imem_rvalid);
  end

  // Fetch FSM with the output register and the flush pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      valid_q      <= 1'b0;
      out_pc_q     <= 32'h0;
      out_ins_q    <= 32'h0;
      out_mis_q    <= 1'b0;
      flush_q      <= 1'b0;
      hold_after_q <= 1'b0;
    end else begin
      flush_q <= taken;
      if (taken) begin
        if (target[1:0] == 2'b00) begin
          pc_q         <= target;
          valid_q      <= 1'b0;
          hold_after_q <= 1'b0;
          state_q      <= in_flight ? S_DISCARD : S_REQ;
        end else begin
          valid_q      <= 1'b1;
          out_pc_q     <= target;
          out_ins_q    <= NOP_INS;
          out_mis_q    <= 1'b1;
          hold_after_q <= in_flight;
          state_q      <= in_flight ? S_DISCARD : S_HOLD;
        end
      end else begin
        if (valid_q && !stall) begin
          valid_q <= 1'b0;
        end
        case (state_q)
          S_REQ: begin
            if (accept) begin
              state_q <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (imem_rvalid) begin
              valid_q   <= 1'b1;
              out_pc_q  <= pc_q;
              out_ins_q <= imem_rdata;
              out_mis_q <= 1'b0;
              pc_q      <= pc_q + 32'd4;
              state_q   <= S_REQ;
            end
          end
          S_DISCARD: begin
            if (imem_rvalid) begin
              state_q      <= hold_after_q ? S_HOLD : S_REQ;
              hold_after_q <= 1'b0;
            end
          end
          default: begin
            state_q <= S_HOLD;
          end
        endcase
      end
    end
  end

  assign if_valid    = valid_q;
  assign if_pc       = out_pc_q;
  assign if_ins      = out_ins_q;
  assign if_misalign = out_mis_q;
  assign pipe_flush  = flush_q;

endmodule

// File: tb/tb_ifetch.sv
// Bench for ifetch: directed scenarios plus a long randomized run, all checked
// against an epoch-tagged behavioural model of the fetch stage and a small
// variable-latency instruction memory.
module tb_ifetch;

  localparam logic [31:0] RPC = 32'h0000_0100;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, taken, stall, imem_ready, imem_rvalid;
  logic [31:0] target, imem_rdata;
  logic        imem_req, if_valid, if_misalign, pipe_flush;
  logic [31:0] imem_addr, if_pc, if_ins;

  int total = 0;
  int bad   = 0;

  ifetch #(.RESET_PC(RPC), .NOP_INS(NOP)) dut (
    .clk(clk), .rst(rst), .taken(taken), .target(target), .stall(stall),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_pc(if_pc), .if_ins(if_ins),
    .if_misalign(if_misalign), .pipe_flush(pipe_flush)
  );

  always #5 clk = ~clk;

  // Reference model: a fetch is tagged with the redirect epoch at issue and
  // its response is only delivered if no redirect happened since.
  logic [31:0] m_pc, m_faddr, m_opc, m_ins;
  int          m_epoch, m_tag;
  bit          m_out, m_halted, m_v, m_mis, m_flush;
  bit          exp_req;
  logic [31:0] exp_addr;

  // Memory model: one pending read, answered after mem_delay cycles.
  bit          mem_pend;
  int          mem_rem;
  int          mem_delay;
  logic [31:0] mem_addr;

  function automatic logic [31:0] hash(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  task automatic drive(input bit t, input logic [31:0] tg, input bit s, input bit rdy);
    taken       = t;
    target      = tg;
    stall       = s;
    imem_ready  = rdy;
    imem_rvalid = mem_pend && (mem_rem == 0);
    imem_rdata  = imem_rvalid ? hash(mem_addr) : $urandom();
    exp_req     = !m_out && !m_halted && (!m_v || !s);
    exp_addr    = m_pc;
    #1;
  endtask

  task automatic tick();
    bit acc;
    int old_epoch;
    acc = exp_req && imem_ready;
    if (m_v && !stall) m_v = 0;
    if (imem_rvalid) begin
      m_out = 0;
      if (!taken && (m_tag == m_epoch)) begin
        m_v = 1; m_opc = m_faddr; m_ins = hash(m_faddr); m_mis = 0;
        m_pc = m_faddr + 32'd4;
      end
    end
    old_epoch = m_epoch;
    m_flush = taken;
    if (taken) begin
      m_epoch++;
      if (target[1:0] == 2'b00) begin
        m_v = 0; m_pc = target; m_halted = 0;
      end else begin
        m_v = 1; m_opc = target; m_ins = NOP; m_mis = 1; m_halted = 1;
      end
    end
    if (acc) begin
      m_out = 1; m_tag = old_epoch; m_faddr = exp_addr;
    end
    if (acc) begin
      mem_pend = 1; mem_rem = mem_delay - 1; mem_addr = exp_addr;
    end else if (imem_rvalid) begin
      mem_pend = 0;
    end else if (mem_pend) begin
      mem_rem--;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic reset_tick();
    rst = 1; taken = 0; target = 0; stall = 0; imem_ready = 0;
    imem_rvalid = 0; imem_rdata = 0;
    m_pc = RPC; m_epoch = 0; m_tag = 0; m_out = 0; m_halted = 0;
    m_v = 0; m_opc = 0; m_ins = 0; m_mis = 0; m_flush = 0; m_faddr = 0;
    mem_pend = 0; mem_rem = 0; mem_addr = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    mem_delay = 1;
    reset_tick();
    total++;
    if (imem_req !== 1'b0) begin bad++; $display("FAIL reset_req got %b want 0", imem_req); end
    reset_tick();
    rst = 0;
    total++;
    if ({if_valid, if_misalign, pipe_flush} !== 3'b000 || if_pc !== 32'h0 || if_ins !== 32'h0) begin
      bad++;
      $display("FAIL reset_outs got v=%b m=%b f=%b pc=%h ins=%h want all zero",
               if_valid, if_misalign, pipe_flush, if_pc, if_ins);
    end
  endtask

  task automatic test_stream();
    logic [31:0] a;
    for (int i = 0; i < 6; i++) begin
      drive(0, 32'h0, 0, 1);
      total++;
      if (i % 2 == 0) begin
        a = RPC + 32'(2 * i);
        if (imem_req !== 1'b1 || imem_addr !== a) begin
          bad++; $display("FAIL stream_req got req=%b addr=%h want 1 %h", imem_req, imem_addr, a);
        end
      end else if (imem_req !== 1'b0) begin
        bad++; $display("FAIL stream_idle got req=%b want 0", imem_req);
      end
      tick();
      if (i % 2 == 1) begin
        a = RPC + 32'(2 * (i - 1));
        total++;
        if (if_valid !== 1'b1 || if_pc !== a || if_ins !== hash(a) || if_misalign !== 1'b0) begin
          bad++; $display("FAIL stream_out got v=%b pc=%h ins=%h want 1 %h %h", if_valid, if_pc, if_ins, a, hash(a));
        end
      end
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 5; i++) begin
      drive(0, 32'h0, 1, 1);
      total++;
      if (imem_req !== 1'b0) begin bad++; $display("FAIL stall_req got %b want 0", imem_req); end
      tick();
      total++;
      if (if_valid !== 1'b1 || if_pc !== 32'h108 || if_ins !== hash(32'h108)) begin
        bad++; $display("FAIL stall_hold got v=%b pc=%h want 1 00000108", if_valid, if_pc);
      end
    end
    mem_delay = 2;
    drive(0, 32'h0, 0, 1);
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h10C) begin
      bad++; $display("FAIL stall_release got req=%b addr=%h want 1 0000010c", imem_req, imem_addr);
    end
    tick();
  endtask

  task automatic test_redirect_wait();
    drive(1, 32'h200, 0, 1);
    tick();
    total++;
    if (pipe_flush !== 1'b1 || if_valid !== 1'b0) begin
      bad++; $display("FAIL redirect_flush got f=%b v=%b want 1 0", pipe_flush, if_valid);
    end
    drive(0, 32'h0, 0, 1);
    total++;
    if (imem_req !== 1'b0) begin bad++; $display("FAIL redirect_discard_req got %b want 0", imem_req); end
    tick();
    total++;
    if (pipe_flush !== 1'b0 || if_valid !== 1'b0) begin
      bad++; $display("FAIL redirect_drop got f=%b v=%b want 0 0", pipe_flush, if_valid);
    end
    drive(0, 32'h0, 0, 0);
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin
      bad++; $display("FAIL redirect_addr got req=%b addr=%h want 1 00000200", imem_req, imem_addr);
    end
    tick();
  endtask

  task automatic test_misalign();
    drive(1, 32'h202, 0, 0);
    tick();
    total++;
    if (if_valid !== 1'b1 || if_misalign !== 1'b1 || if_pc !== 32'h202 || if_ins !== NOP || pipe_flush !== 1'b1) begin
      bad++; $display("FAIL misalign_bubble got v=%b m=%b pc=%h ins=%h f=%b want 1 1 00000202 00000013 1",
                      if_valid, if_misalign, if_pc, if_ins, pipe_flush);
    end
    for (int i = 0; i < 4; i++) begin
      drive(0, 32'h0, 0, 1);
      total++;
      if (imem_req !== 1'b0) begin bad++; $display("FAIL misalign_hold got req=%b want 0", imem_req); end
      tick();
    end
    drive(1, 32'h80, 0, 0);
    tick();
    drive(0, 32'h0, 0, 0);
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h80) begin
      bad++; $display("FAIL misalign_restart got req=%b addr=%h want 1 00000080", imem_req, imem_addr);
    end
    tick();
  endtask

  task automatic test_wrap();
    mem_delay = 1;
    drive(1, 32'hFFFF_FFFC, 0, 0);
    tick();
    drive(0, 32'h0, 0, 1);
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin
      bad++; $display("FAIL wrap_req got req=%b addr=%h want 1 fffffffc", imem_req, imem_addr);
    end
    tick();
    drive(0, 32'h0, 0, 1);
    tick();
    total++;
    if (if_valid !== 1'b1 || if_pc !== 32'hFFFF_FFFC || if_ins !== hash(32'hFFFF_FFFC)) begin
      bad++; $display("FAIL wrap_out got v=%b pc=%h want 1 fffffffc", if_valid, if_pc);
    end
    drive(0, 32'h0, 1, 0);
    total++;
    if (imem_req !== 1'b0 || imem_addr !== 32'h0) begin
      bad++; $display("FAIL wrap_next got req=%b addr=%h want 0 00000000", imem_req, imem_addr);
    end
    tick();
  endtask

  task automatic test_taken_stall();
    drive(1, 32'h300, 1, 0);
    tick();
    total++;
    if (if_valid !== 1'b0 || pipe_flush !== 1'b1) begin
      bad++; $display("FAIL taken_stall got v=%b f=%b want 0 1", if_valid, pipe_flush);
    end
    drive(1, 32'h304, 0, 0);
    tick();
    total++;
    if (pipe_flush !== 1'b1) begin bad++; $display("FAIL back_to_back_flush got %b want 1", pipe_flush); end
    drive(0, 32'h0, 0, 0);
    tick();
    total++;
    if (pipe_flush !== 1'b0) begin bad++; $display("FAIL flush_end got %b want 0", pipe_flush); end
  endtask

  task automatic test_reset_wait();
    mem_delay = 3;
    drive(0, 32'h0, 0, 1);
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h304) begin
      bad++; $display("FAIL rstwait_req got req=%b addr=%h want 1 00000304", imem_req, imem_addr);
    end
    tick();
    drive(0, 32'h0, 0, 0);
    tick();
    reset_tick();
    rst = 0;
    total++;
    if ({if_valid, if_misalign, pipe_flush} !== 3'b000 || if_pc !== 32'h0 || if_ins !== 32'h0) begin
      bad++; $display("FAIL rstwait_outs got v=%b m=%b f=%b pc=%h ins=%h want all zero",
                      if_valid, if_misalign, pipe_flush, if_pc, if_ins);
    end
    drive(0, 32'h0, 0, 0);
    total++;
    if (imem_req !== 1'b1 || imem_addr !== RPC) begin
      bad++; $display("FAIL rstwait_restart got req=%b addr=%h want 1 %h", imem_req, imem_addr, RPC);
    end
    tick();
  endtask

  task automatic test_random();
    logic [31:0] tg;
    int          r;
    bit          t, s, rdy;
    for (int i = 0; i < 3000; i++) begin
      t   = ($urandom_range(0, 9) == 0);
      s   = ($urandom_range(0, 2) == 0);
      rdy = ($urandom_range(0, 1) == 1);
      r   = $urandom_range(0, 9);
      tg  = $urandom();
      if (r <= 5) tg[1:0] = 2'b00;
      else if (r <= 7) tg[1:0] = 2'($urandom_range(1, 3));
      else tg = (r == 8) ? 32'hFFFF_FFF8 : 32'hFFFF_FFFC;
      mem_delay = $urandom_range(1, 3);
      drive(t, tg, s, rdy);
      total++;
      if (imem_req !== exp_req || (exp_req && imem_addr !== exp_addr)) begin
        bad++; $display("FAIL rand_req cyc=%0d got req=%b addr=%h want %b %h", i, imem_req, imem_addr, exp_req, exp_addr);
      end
      tick();
      total++;
      if (if_valid !== m_v || pipe_flush !== m_flush ||
          (m_v && (if_pc !== m_opc || if_ins !== m_ins || if_misalign !== m_mis))) begin
        bad++; $display("FAIL rand_out cyc=%0d got v=%b f=%b pc=%h ins=%h m=%b want %b %b %h %h %b",
                        i, if_valid, pipe_flush, if_pc, if_ins, if_misalign, m_v, m_flush, m_opc, m_ins, m_mis);
      end
    end
  endtask

  initial begin
    rst = 1; taken = 0; target = 0; stall = 0; imem_ready = 0;
    imem_rvalid = 0; imem_rdata = 0; mem_delay = 1;
    test_reset();
    test_stream();
    test_stall();
    test_redirect_wait();
    test_misalign();
    test_wrap();
    test_taken_stall();
    test_reset_wait();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
